// File: rtl/vga_rgb_pattern_gen.sv
// ============================================================================
//  Module   : vga_rgb_pattern_gen
//  Purpose  : VGA 640x480@60 sync/DE timing plus registered RGB test patterns.
//             Optional macro VGA_ANIM_EN scrolls the patterns 1 px per frame.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_rgb_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] mode,
    output logic [7:0] dr,
    output logic [7:0] dg,
    output logic [7:0] db,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic       frame_start
);

    localparam int         c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_H_LAST  = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST  = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] c_V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] c_HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_BAR_W   = 10'd80;

    logic [9:0]  r_h;
    logic [9:0]  r_v;
    logic [1:0]  r_mode_q;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_first;
    logic        w_de;
    logic        w_hs;
    logic        w_vs;
    logic [1:0]  w_mode;
    logic [7:0]  w_offset;
    logic [9:0]  w_x;
    logic [2:0]  w_bar;
    logic [23:0] w_rgb;

    assign w_h_wrap = (r_h == c_H_LAST);
    assign w_v_wrap = (r_v == c_V_LAST);
    assign w_first  = (r_h == 10'd0) && (r_v == 10'd0);

    // The first pixel of a frame already uses the freshly sampled mode.
    assign w_mode   = w_first ? mode : r_mode_q;

    assign w_de     = (r_h < c_H_ACT) && (r_v < c_V_ACT);
    assign w_hs     = (r_h >= c_HS_BEG) && (r_h < c_HS_END);
    assign w_vs     = (r_v >= c_VS_BEG) && (r_v < c_VS_END);

`ifdef VGA_ANIM_EN
    logic [7:0] r_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= 8'd0;
        end else if (ena && w_h_wrap && w_v_wrap) begin
            r_frame <= r_frame + 8'd1;
        end
    end

    assign w_offset = r_frame;
`else
    assign w_offset = 8'd0;
`endif

    assign w_x   = r_h + {2'b00, w_offset};
    assign w_bar = 3'(w_x / c_BAR_W);

    always_comb begin
        w_rgb = 24'h000000;
        if (w_de) begin
            case (w_mode)
                2'd0: begin
                    case (w_bar)
                        3'd0:    w_rgb = 24'hFFFFFF;
                        3'd1:    w_rgb = 24'hFFFF00;
                        3'd2:    w_rgb = 24'h00FFFF;
                        3'd3:    w_rgb = 24'h00FF00;
                        3'd4:    w_rgb = 24'hFF00FF;
                        3'd5:    w_rgb = 24'hFF0000;
                        3'd6:    w_rgb = 24'h0000FF;
                        default: w_rgb = 24'h000000;
                    endcase
                end
                2'd1:    w_rgb = {w_x[7:0], r_v[7:0], w_x[7:0] ^ r_v[7:0]};
                2'd2:    w_rgb = (w_x[5] ^ r_v[5]) ? 24'hFFFFFF : 24'h000000;
                default: w_rgb = 24'h808080;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h         <= 10'd0;
            r_v         <= 10'd0;
            r_mode_q    <= 2'd0;
            dr          <= 8'h00;
            dg          <= 8'h00;
            db          <= 8'h00;
            de          <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
        end else if (ena) begin
            if (w_first) begin
                r_mode_q <= mode;
            end
            r_h <= w_h_wrap ? 10'd0 : r_h + 10'd1;
            if (w_h_wrap) begin
                r_v <= w_v_wrap ? 10'd0 : r_v + 10'd1;
            end
            {dr, dg, db} <= w_rgb;
            de           <= w_de;
            frame_start  <= w_first;
            hsync        <= w_hs ? SYNC_POL : ~SYNC_POL;
            vsync        <= w_vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vga_rgb_pattern_gen.sv
// ============================================================================
//  Module   : tb_vga_rgb_pattern_gen
//  Purpose  : Directed self-checking bench for vga_rgb_pattern_gen (short frame).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_rgb_pattern_gen;

    localparam int c_H_TOT = 800;
    localparam int c_V_TOT = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [1:0] mode;
    logic [7:0] dr, dg, db;
    logic       hsync, vsync, de, frame_start;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Full horizontal timing, vertical shrunk to 24 active lines / 30 total.
    vga_rgb_pattern_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(24),  .V_FP(2),  .V_SYNC(2),  .V_BP(2),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode),
        .dr(dr), .dg(dg), .db(db),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    typedef struct {
        int         f;
        int         v;
        int         h;
        logic [23:0] rgb;
        logic [3:0]  flg;   // {hsync, vsync, de, frame_start}
    } probe_t;

    probe_t probes[$];

    int nh, nv, nf, ph, pv, pf;
    bit probes_on;
    int cnt_hs, cnt_vs, cnt_de, cnt_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int f, input int v, input int h,
                       input logic [23:0] rgb, input logic [3:0] flg);
        probe_t p;
        p.f = f; p.v = v; p.h = h; p.rgb = rgb; p.flg = flg;
        probes.push_back(p);
    endtask

    // One clock; outputs after the edge belong to the position counted at it.
    task automatic step();
        bit adv;
        adv = (ena === 1'b1);
        @(posedge clk);
        #1;
        if (adv) begin
            ph = nh; pv = nv; pf = nf;
            if (nh == c_H_TOT - 1) begin
                nh = 0;
                if (nv == c_V_TOT - 1) begin
                    nv = 0;
                    nf++;
                end else begin
                    nv++;
                end
            end else begin
                nh++;
            end
            if (probes_on) begin
                if (pf == 0) begin
                    if (hsync === 1'b0)      cnt_hs++;
                    if (vsync === 1'b0)      cnt_vs++;
                    if (de === 1'b1)         cnt_de++;
                    if (frame_start === 1'b1) cnt_fs++;
                end
                foreach (probes[i]) begin
                    if (probes[i].f == pf && probes[i].v == pv && probes[i].h == ph) begin
                        chk($sformatf("rgb f%0d v%0d h%0d", pf, pv, ph),
                            {8'h00, dr, dg, db}, {8'h00, probes[i].rgb});
                        chk($sformatf("flags f%0d v%0d h%0d", pf, pv, ph),
                            {28'h0, hsync, vsync, de, frame_start}, {28'h0, probes[i].flg});
                    end
                end
            end
        end
    endtask

    initial begin
        bit done;
        bit agg_done;
        bit ena_done;
        int bad;

        rst_n = 1'b0; ena = 1'b1; mode = 2'd0;
        nh = 0; nv = 0; nf = 0; ph = 0; pv = 0; pf = 0;
        probes_on = 1'b0; done = 1'b0; agg_done = 1'b0; ena_done = 1'b0;
        cnt_hs = 0; cnt_vs = 0; cnt_de = 0; cnt_fs = 0;

        // Frame 0: colour bars, boundaries of bars, hsync and vsync windows.
        add(0, 0,   0, 24'hFFFFFF, 4'b1111);
        add(0, 0,  79, 24'hFFFFFF, 4'b1110);
        add(0, 0,  80, 24'hFFFF00, 4'b1110);
        add(0, 0, 160, 24'h00FFFF, 4'b1110);
        add(0, 0, 240, 24'h00FF00, 4'b1110);
        add(0, 0, 320, 24'hFF00FF, 4'b1110);
        add(0, 0, 400, 24'hFF0000, 4'b1110);
        add(0, 0, 480, 24'h0000FF, 4'b1110);
        add(0, 0, 559, 24'h0000FF, 4'b1110);
        add(0, 0, 560, 24'h000000, 4'b1110);
        add(0, 0, 639, 24'h000000, 4'b1110);
        add(0, 0, 640, 24'h000000, 4'b1100);
        add(0, 0, 655, 24'h000000, 4'b1100);
        add(0, 0, 656, 24'h000000, 4'b0100);
        add(0, 0, 751, 24'h000000, 4'b0100);
        add(0, 0, 752, 24'h000000, 4'b1100);
        add(0, 11,  0, 24'hFFFFFF, 4'b1110);
        add(0, 23,  0, 24'hFFFFFF, 4'b1110);
        add(0, 23, 639, 24'h000000, 4'b1110);
        add(0, 24, 10, 24'h000000, 4'b1100);
        add(0, 25, 799, 24'h000000, 4'b1100);
        add(0, 26,  0, 24'h000000, 4'b1000);
        add(0, 27, 656, 24'h000000, 4'b0000);
        add(0, 28,  0, 24'h000000, 4'b1100);
        // Frame 1: checker latched at frame start; enable-hold line v=2.
        add(1, 0,   0, 24'h000000, 4'b1111);
        add(1, 0,  30, 24'h000000, 4'b1110);
        add(1, 0,  32, 24'hFFFFFF, 4'b1110);
        add(1, 2, 300, 24'hFFFFFF, 4'b1110);
        add(1, 2, 301, 24'hFFFFFF, 4'b1110);
        add(1, 2, 318, 24'hFFFFFF, 4'b1110);
        add(1, 2, 320, 24'h000000, 4'b1110);
        add(1, 2, 600, 24'h000000, 4'b1110);
        add(1, 2, 656, 24'h000000, 4'b0100);
        // Frame 2: gradient.
`ifdef VGA_ANIM_EN
        add(2, 0,   0, 24'h020002, 4'b1111);
        add(2, 20, 10, 24'h0C1418, 4'b1110);
        add(2, 20, 639, 24'h811495, 4'b1110);
`else
        add(2, 0,   0, 24'h000000, 4'b1111);
        add(2, 20, 10, 24'h0A141E, 4'b1110);
        add(2, 20, 639, 24'h7F146B, 4'b1110);
`endif
        add(2, 20, 640, 24'h000000, 4'b1100);

        // Reset values while held.
        repeat (3) @(negedge clk);
        chk("reset_rgb", {8'h00, dr, dg, db}, 32'h0);
        chk("reset_flags", {28'h0, hsync, vsync, de, frame_start}, {28'h0, 4'b1100});

        // Run into line 0, then assert reset between clock edges.
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 201; k++) step();
        chk("pre_reset_px200", {8'h00, dr, dg, db}, {8'h00, 24'h00FFFF});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_rgb", {8'h00, dr, dg, db}, 32'h0);
        chk("async_reset_flags", {28'h0, hsync, vsync, de, frame_start}, {28'h0, 4'b1100});

        @(negedge clk) rst_n = 1'b1;
        nh = 0; nv = 0; nf = 0;
        probes_on = 1'b1;

        for (int k = 0; k < 70000 && !done; k++) begin
            step();
            if (pf == 0 && pv == 10 && ph == 0) mode = 2'd2;
            if (pf == 1 && pv == 0 && ph == 0 && !agg_done) begin
                agg_done = 1'b1;
                chk("frame_hsync_cycles", cnt_hs, 96 * 30);
                chk("frame_vsync_cycles", cnt_vs, 2 * 800);
                chk("frame_de_cycles",    cnt_de, 640 * 24);
                chk("frame_start_count",  cnt_fs, 1);
            end
            if (pf == 1 && pv == 2 && ph == 300 && !ena_done) begin
                ena_done = 1'b1;
                ena = 1'b0;
                bad = 0;
                for (int j = 0; j < 50; j++) begin
                    step();
                    if ({dr, dg, db} !== 24'hFFFFFF || de !== 1'b1 ||
                        hsync !== 1'b1 || frame_start !== 1'b0) bad++;
                end
                chk("ena_hold_frozen", bad, 0);
                ena = 1'b1;
            end
            if (pf == 1 && pv == 5 && ph == 0) mode = 2'd1;
            if (pf == 2 && pv == 21) done = 1'b1;
        end
        chk("run_completed", {31'h0, done}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
